conv_loop_controller: RTL
=========================

CONV_LOOP_CONTROLLER -- requirements
Module: conv_loop_controller

Interface
REQ-001 SHALL have parameter FEATURE_MAP_WIDTH, default 8: output feature-map columns.
REQ-002 SHALL have parameter FEATURE_MAP_HEIGHT, default 8: output feature-map rows.
REQ-003 SHALL have parameter INPUT_NB_CHANNELS, default 2: input channels per output.
REQ-004 SHALL have parameter OUTPUT_NB_CHANNELS, default 4: output channels.
REQ-005 SHALL have parameter KERNEL_SIZE, default 3: square kernel side.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk  input  1: sole clock, all state updates on rising edge.
REQ-008 SHALL have port rst  input  1: synchronous active-high reset.
REQ-009 SHALL have port start  input  1: single-cycle request to run one full layer.
REQ-010 SHALL have port running  output  1: layer in progress.
REQ-011 SHALL have port a_valid  input  1: activation operand available.
REQ-012 SHALL have port a_ready  output  1: activation operand accepted.
REQ-013 SHALL have port b_valid  input  1: weight operand available.
REQ-014 SHALL have port b_ready  output  1: weight operand accepted.
REQ-015 SHALL have port mac_en  output  1: datapath multiply-accumulates the operands transferred this cycle.
REQ-016 SHALL have port mac_clear  output  1: accumulator loads the product instead of adding it.
REQ-017 SHALL have port k_x, k_y  output  clog2(KERNEL_SIZE) each: kernel indices of the current term.
REQ-018 SHALL have port k_ch  output  clog2(INPUT_NB_CHANNELS): input-channel index of the current term.
REQ-019 SHALL have port output_valid  output  1: accumulator holds a finished output.
REQ-020 SHALL have ports output_x, output_y, output_ch  output  clog2(FEATURE_MAP_WIDTH), clog2(FEATURE_MAP_HEIGHT), clog2(OUTPUT_NB_CHANNELS): coordinates of the current output. Each width SHALL be at least 1.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, OUTPUT.
REQ-022 IDLE: start=1 -> FETCH next cycle, all counters zero; start is ignored in FETCH and OUTPUT.
REQ-023 FETCH: a_ready = b_valid, b_ready = a_valid (joint handshake); fire = a_valid & b_valid; a single-side transfer SHALL never occur.
REQ-024 mac_en SHALL equal fire (combinational, same cycle as transfer); mac_clear = fire & (k_x==0 & k_y==0 & k_ch==0).
REQ-025 Inner loop order on each fire: k_x fastest, then k_y, then k_ch; each wraps to 0 at its limit.
REQ-026 Fire on the last term (all inner indices at maximum): inner counters wrap to 0, FSM -> OUTPUT.
REQ-027 OUTPUT: output_valid=1 for exactly one cycle, a_ready=b_ready=0, output_x/y/ch show the finished output.
REQ-028 Leaving OUTPUT: outer loop advances with output_ch fastest, then output_x, then output_y; after the final output (all at maximum) FSM -> IDLE with outer counters at 0, else -> FETCH.
REQ-029 running SHALL be 1 in FETCH and OUTPUT, 0 in IDLE.
REQ-030 Per-output latency SHALL be K*K*Cin fire cycles + 1 OUTPUT cycle; valid-stall cycles add 1:1.
REQ-031 Outside FETCH, a_ready, b_ready, mac_en and mac_clear SHALL be 0.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE and zero all counters, regardless of state; it overrides start and fire in the same cycle.
REQ-033 After reset, all outputs SHALL be 0: running, a_ready, b_ready, mac_en, mac_clear, output_valid, indices and coordinates.

Verification
REQ-034 Config W=2,H=2,Cin=2,Cout=2,K=3 with a_valid=b_valid=1 continuously and start pulse -> 8 output_valid pulses, each 19 cycles apart, coordinates in order (ch,x,y) = (0,0,0),(1,0,0),(0,1,0)...(1,1,1); then running=0.
REQ-035 Same config, a_valid toggling every cycle and b_valid=1 -> a_ready/b_ready never high with their partner valid low, 18 fires per output, mac_clear exactly once per output on its first fire.
REQ-036 start held high for the entire run -> exactly one layer of 8 outputs; a new run starts the cycle after returning to IDLE.
REQ-037 rst asserted during the 5th output's FETCH with fire=1 -> next cycle IDLE, all outputs 0, and no output_valid pulse.
REQ-038 Config K=1,Cin=1,W=H=Cout=1 -> fire, then output_valid at coordinates (0,0,0), then IDLE; running high for 2 cycles.

Source files
------------

// File: rtl/conv_loop_controller.sv
// ============================================================================
// conv_loop_controller
//
// Loop sequencer for a convolution layer. Each output is one accumulation
// over K*K*Cin terms. Two operands move together on each term: an activation
// (a_*) and a weight (b_*). A term transfers, or "fires", only when both
// sides are valid. After the last term the controller spends one cycle in
// OUTPUT, where the finished accumulator is flagged. It then moves to the
// next output coordinate.
//
// Loop nest, outermost first:
//   output_y > output_x > output_ch > k_ch > k_y > k_x
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request one full layer (only seen in IDLE)
//   running      out  layer in progress (FETCH or OUTPUT)
//   a_valid      in   activation operand available
//   a_ready      out  activation operand accepted (= b_valid in FETCH)
//   b_valid      in   weight operand available
//   b_ready      out  weight operand accepted (= a_valid in FETCH)
//   mac_en       out  multiply-accumulate the operands transferred this cycle
//   mac_clear    out  load the product instead of adding (first term)
//   k_x, k_y     out  kernel indices of the current term
//   k_ch         out  input-channel index of the current term
//   output_valid out  accumulator holds a finished output (one cycle)
//   output_x/y/ch out coordinates of the current output
// ============================================================================
module conv_loop_controller #(
    parameter int FEATURE_MAP_WIDTH  = 8,
    parameter int FEATURE_MAP_HEIGHT = 8,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 4,
    parameter int KERNEL_SIZE        = 3,
    // Index widths. A dimension of size 1 still gets a 1-bit port.
    localparam int KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1,
    localparam int ICW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
    localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
    localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
    localparam int OCW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           running,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic           b_valid,
    output logic           b_ready,
    output logic           mac_en,
    output logic           mac_clear,
    output logic [KW-1:0]  k_x,
    output logic [KW-1:0]  k_y,
    output logic [ICW-1:0] k_ch,
    output logic           output_valid,
    output logic [XW-1:0]  output_x,
    output logic [YW-1:0]  output_y,
    output logic [OCW-1:0] output_ch
);

    localparam logic [KW-1:0]  K_LAST  = KW'(KERNEL_SIZE - 1);
    localparam logic [ICW-1:0] IC_LAST = ICW'(INPUT_NB_CHANNELS - 1);
    localparam logic [XW-1:0]  X_LAST  = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [OCW-1:0] OC_LAST = OCW'(OUTPUT_NB_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        OUTPUT
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  kx_q, kx_d;
    logic [KW-1:0]  ky_q, ky_d;
    logic [ICW-1:0] kch_q, kch_d;
    logic [XW-1:0]  ox_q, ox_d;
    logic [YW-1:0]  oy_q, oy_d;
    logic [OCW-1:0] och_q, och_d;

    logic fire;
    logic first_term;
    logic last_term;
    logic last_output;

    assign first_term  = (kx_q == '0) && (ky_q == '0) && (kch_q == '0);
    assign last_term   = (kx_q == K_LAST) && (ky_q == K_LAST) && (kch_q == IC_LAST);
    assign last_output = (och_q == OC_LAST) && (ox_q == X_LAST) && (oy_q == Y_LAST);

    // NOTE: every signal this block drives gets a default first. A path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        kx_d         = kx_q;
        ky_d         = ky_q;
        kch_d        = kch_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        och_d        = och_q;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        fire         = 1'b0;
        mac_en       = 1'b0;
        mac_clear    = 1'b0;
        output_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    kx_d    = '0;
                    ky_d    = '0;
                    kch_d   = '0;
                    ox_d    = '0;
                    oy_d    = '0;
                    och_d   = '0;
                end
            end

            FETCH: begin
                // Each ready is tied to the partner's valid. One side can
                // therefore never complete a transfer while the other waits.
                a_ready   = b_valid;
                b_ready   = a_valid;
                fire      = a_valid & b_valid;
                mac_en    = fire;
                mac_clear = fire & first_term;
                if (fire) begin
                    if (kx_q == K_LAST) begin
                        kx_d = '0;
                        if (ky_q == K_LAST) begin
                            ky_d = '0;
                            if (kch_q == IC_LAST) begin
                                kch_d = '0;
                            end else begin
                                kch_d = kch_q + 1'b1;
                            end
                        end else begin
                            ky_d = ky_q + 1'b1;
                        end
                    end else begin
                        kx_d = kx_q + 1'b1;
                    end
                    if (last_term) begin
                        state_d = OUTPUT;
                    end
                end
            end

            OUTPUT: begin
                output_valid = 1'b1;
                // Wrapping every outer counter on the final output leaves
                // them all at zero for IDLE.
                if (och_q == OC_LAST) begin
                    och_d = '0;
                    if (ox_q == X_LAST) begin
                        ox_d = '0;
                        if (oy_q == Y_LAST) begin
                            oy_d = '0;
                        end else begin
                            oy_d = oy_q + 1'b1;
                        end
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                end else begin
                    och_d = och_q + 1'b1;
                end
                state_d = last_output ? IDLE : FETCH;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever order the statements
    // are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kx_q    <= '0;
            ky_q    <= '0;
            kch_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            och_q   <= '0;
        end else begin
            state_q <= state_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            kch_q   <= kch_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            och_q   <= och_d;
        end
    end

    assign running   = (state_q != IDLE);
    assign k_x       = kx_q;
    assign k_y       = ky_q;
    assign k_ch      = kch_q;
    assign output_x  = ox_q;
    assign output_y  = oy_q;
    assign output_ch = och_q;

endmodule
